// File: rtl/ahb_sram64_pkg.sv
// Shared encodings and helpers for the AHB-Lite to 64-bit SRAM bridge.
package ahb_sram64_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ADDR  = 2'd1,
    WB_FULL  = 2'd2
  } wbuf_state_e;

  // Byte lanes of the 64-bit SRAM word touched by a transfer; oversize is word.
  function automatic logic [7:0] lane_mask(input logic [2:0] a, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      HSIZE_BYTE: m = 8'h01 << a;
      HSIZE_HALF: m = 8'h03 << {a[2:1], 1'b0};
      default:    m = 8'h0F << {a[2], 2'b00};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram64_wbuf.sv
// Single-entry posted write buffer: captures address/mask, then data, and
// commits when the SRAM port is free; also flags bytes to forward to reads.
module ahb_sram64_wbuf
  import ahb_sram64_pkg::*;
#(
  parameter int WAW = 12
) (
  input  logic           CLK,
  input  logic           RESETn,
  input  logic           wr_acc_i,
  input  logic           rd_acc_i,
  input  logic [WAW-1:0] wr_addr_i,
  input  logic [7:0]     wr_mask_i,
  input  logic [31:0]    hwdata_i,
  input  logic           rd_dphase_i,
  input  logic [WAW-1:0] rd_addr_i,
  output logic           cmt_o,
  output logic [WAW-1:0] cmt_addr_o,
  output logic [7:0]     cmt_wen_o,
  output logic [63:0]    cmt_data_o,
  output logic [7:0]     fwd_mask_o,
  output logic [31:0]    fwd_data_o
);

  wbuf_state_e    state_q, state_d;
  logic [WAW-1:0] addr_q;
  logic [7:0]     mask_q;
  logic [31:0]    data_q;
  logic [31:0]    cmt_word;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= WB_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wr_acc_i) begin
      state_d = WB_ADDR;
    end else begin
      case (state_q)
        WB_ADDR: state_d = WB_FULL;
        WB_FULL: if (!rd_acc_i) state_d = WB_EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  // A write accepted during the previous write's data phase commits the older
  // entry straight from HWDATA, so the buffer never needs a second slot.
  always_comb begin
    cmt_o      = ((state_q == WB_FULL) && !rd_acc_i) || ((state_q == WB_ADDR) && wr_acc_i);
    cmt_word   = (state_q == WB_FULL) ? data_q : hwdata_i;
    cmt_addr_o = addr_q;
    cmt_wen_o  = ~mask_q;
    cmt_data_o = {cmt_word, cmt_word};
    fwd_mask_o = ((state_q == WB_FULL) && rd_dphase_i && (addr_q == rd_addr_i)) ? mask_q : 8'h00;
    fwd_data_o = data_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      if (wr_acc_i) begin
        addr_q <= wr_addr_i;
        mask_q <= wr_mask_i;
      end
      if (state_q == WB_ADDR) data_q <= hwdata_i;
    end
  end

endmodule

// File: rtl/ahb_sram64_bridge.sv
// Zero-wait-state AHB-Lite slave in front of a 64-bit wide synchronous SRAM,
// with a posted write buffer so writes never stall the bus.
module ahb_sram64_bridge
  import ahb_sram64_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic          SRAM_CEn,
  output logic [7:0]    SRAM_WEn,
  output logic [AW-4:0] SRAM_A,
  output logic [63:0]   SRAM_D,
  input  logic [63:0]   SRAM_Q
);

  localparam int WAW       = AW - 3;
  localparam int NUM_LANES = 4;

  logic           acc, rd_acc, wr_acc;
  logic [AW-3:0]  rd_addr_q;
  logic           rd_dphase_q;
  logic           cmt;
  logic [WAW-1:0] cmt_addr;
  logic [7:0]     cmt_wen;
  logic [63:0]    cmt_data;
  logic [7:0]     fwd_mask;
  logic [31:0]    fwd_data;

  // Gated by reset so the macro is never enabled while the bridge is held.
  assign acc    = HSEL & HTRANS[1] & HREADY & RESETn;
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_addr_q   <= '0;
      rd_dphase_q <= 1'b0;
    end else begin
      rd_dphase_q <= rd_acc;
      if (rd_acc) rd_addr_q <= HADDR[AW-1:2];
    end
  end

  ahb_sram64_wbuf #(.WAW(WAW)) u_wbuf (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .wr_acc_i    (wr_acc),
    .rd_acc_i    (rd_acc),
    .wr_addr_i   (HADDR[AW-1:3]),
    .wr_mask_i   (lane_mask(HADDR[2:0], HSIZE)),
    .hwdata_i    (HWDATA),
    .rd_dphase_i (rd_dphase_q),
    .rd_addr_i   (rd_addr_q[AW-3:1]),
    .cmt_o       (cmt),
    .cmt_addr_o  (cmt_addr),
    .cmt_wen_o   (cmt_wen),
    .cmt_data_o  (cmt_data),
    .fwd_mask_o  (fwd_mask),
    .fwd_data_o  (fwd_data)
  );

  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = 8'hFF;
    SRAM_A   = cmt_addr;
    SRAM_D   = cmt_data;
    if (rd_acc) begin
      SRAM_CEn = 1'b0;
      SRAM_A   = HADDR[AW-1:3];
    end else if (cmt) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = cmt_wen;
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic       fwd;
    logic [7:0] q_byte;
    assign fwd    = rd_addr_q[0] ? fwd_mask[NUM_LANES+j] : fwd_mask[j];
    assign q_byte = rd_addr_q[0] ? SRAM_Q[32+8*j +: 8] : SRAM_Q[8*j +: 8];
    assign HRDATA[8*j +: 8] = fwd ? fwd_data[8*j +: 8] : q_byte;
  end

endmodule

// File: tb/tb_ahb_sram64_bridge.sv
// Scoreboard bench: a flat byte-array reference memory predicts every read;
// a monitor pops predictions in each read data phase and logs SRAM commits.
module tb_ahb_sram64_bridge;

  localparam int AW = 15;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic          CLK, RESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAM_CEn;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA, HRDATA;
  logic [7:0]    SRAM_WEn;
  logic [AW-4:0] SRAM_A;
  logic [63:0]   SRAM_D, SRAM_Q;

  ahb_sram64_bridge #(.AW(AW)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .SRAM_CEn(SRAM_CEn),
    .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0] smem [4096];
  logic [7:0]  ref_mem [32768];
  logic [31:0] exp_q [$];
  logic [11:0] cl_a [$];
  logic [7:0]  cl_wen [$];
  logic [63:0] cl_d [$];
  logic [31:0] nxt_wd, last_rd;
  logic        rd_ph;
  int          n_chk, n_fail, cen_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM macro: synchronous read, byte-masked write
  always @(posedge CLK) begin
    if (!SRAM_CEn) begin
      if (SRAM_WEn == 8'hFF) SRAM_Q <= smem[SRAM_A];
      else for (int b = 0; b < 8; b++)
        if (!SRAM_WEn[b]) smem[SRAM_A][8*b +: 8] <= SRAM_D[8*b +: 8];
    end
  end

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) rd_ph <= 1'b0;
    else         rd_ph <= HSEL && HTRANS[1] && HREADY && !HWRITE;
  end

  always @(negedge CLK) begin
    if (RESETn) begin
      check("hreadyout", {63'd0, HREADYOUT}, 64'd1);
      check("hresp", {63'd0, HRESP}, 64'd0);
    end
    if (rd_ph) begin
      if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else begin
        check("hrdata", {32'd0, HRDATA}, {32'd0, exp_q.pop_front()});
        last_rd = HRDATA;
      end
    end
    if (!SRAM_CEn) begin
      cen_cnt++;
      if (SRAM_WEn != 8'hFF) begin
        cl_a.push_back(SRAM_A);
        cl_wen.push_back(SRAM_WEn);
        cl_d.push_back(SRAM_D);
      end
    end
  end

  function automatic int xfer_bytes(input logic [2:0] sz);
    return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n, base;
    n = xfer_bytes(sz);
    base = int'(a) & ~(n - 1);
    for (int k = 0; k < n; k++) ref_mem[base+k] = wd[8*((base+k)%4) +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    int base;
    base = int'(a) & ~3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  // One bus cycle: address phase of this transfer plus data phase of the last.
  task automatic bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [AW-1:0] a,
                     input logic [2:0] sz, input logic [31:0] wd, input logic hr, input bit keep);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HREADY = hr;
    HWDATA = nxt_wd;
    nxt_wd = 32'd0;
    if (sel && tr[1] && hr) begin
      if (wr) begin
        nxt_wd = wd;
        if (keep) ref_write(a, sz, wd);
      end else begin
        exp_q.push_back(ref_word(a));
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, T_IDLE, 1'b0, '0, 3'd2, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bus(1'b1, T_NSEQ, 1'b1, a, sz, wd, 1'b1, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus(1'b1, T_NSEQ, 1'b0, a, 3'd2, 32'd0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base, cb;
    logic [AW-1:0] a;
    logic [2:0] sz;
    n_chk = 0; n_fail = 0; cen_cnt = 0; nxt_wd = 32'd0; last_rd = 32'd0;
    for (int w = 0; w < 4096; w++) smem[w] = {$urandom, $urandom};
    smem[0][31:0] = 32'h1122_3344;
    for (int w = 0; w < 4096; w++)
      for (int b = 0; b < 8; b++) ref_mem[8*w+b] = smem[w][8*b +: 8];

    // Reset with an active read request on the bus: macro must stay idle
    RESETn = 1'b0; HSEL = 1'b1; HTRANS = T_NSEQ; HWRITE = 1'b0; HADDR = '0;
    HSIZE = 3'd2; HREADY = 1'b1; HWDATA = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cen", {63'd0, SRAM_CEn}, 64'd1);
    check("rst_wen", {56'd0, SRAM_WEn}, 64'hFF);
    check("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    check("rst_hresp", {63'd0, HRESP}, 64'd0);
    HSEL = 1'b0; HTRANS = T_IDLE;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    idle(2);

    // Word write then idle: exactly one commit to the upper half
    cb = cl_a.size();
    wr(15'h0104, 3'd2, 32'hDEAD_BEEF);
    idle(3);
    check("t1_ncommit", 64'(cl_a.size() - cb), 64'd1);
    if (cl_a.size() > cb) begin
      check("t1_addr", {52'd0, cl_a[cb]}, 64'h020);
      check("t1_wen", {56'd0, cl_wen[cb]}, 64'h0F);
      check("t1_dhi", {32'd0, cl_d[cb][63:32]}, 64'hDEAD_BEEF);
    end

    // Byte write immediately followed by a read of the same word
    wr(15'h0003, 3'd0, 32'h5500_0000);
    rd(15'h0000);
    idle(2);
    check("t2_fwd", {32'd0, last_rd}, 64'h5522_3344);

    // Write held across back-to-back reads, committed at first idle
    cb = cl_a.size();
    wr(15'h0008, 3'd2, 32'hCAFE_F00D);
    rd(15'h0008); rd(15'h0040); rd(15'h000C); rd(15'h0044); rd(15'h0010);
    check("t3_no_commit", 64'(cl_a.size() - cb), 64'd0);
    idle(1);
    check("t3_commit", 64'(cl_a.size() - cb), 64'd1);
    idle(2);
    rd(15'h0008);
    idle(2);
    check("t3_readback", {32'd0, last_rd}, 64'hCAFE_F00D);

    // Back-to-back halfword writes commit in order
    cb = cl_a.size();
    wr(15'h0010, 3'd1, 32'h0000_AAAA);
    wr(15'h0012, 3'd1, 32'hBBBB_0000);
    idle(3);
    check("t4_ncommit", 64'(cl_a.size() - cb), 64'd2);
    if (cl_a.size() >= cb + 2) begin
      check("t4_wen0", {56'd0, cl_wen[cb]}, 64'hFC);
      check("t4_wen1", {56'd0, cl_wen[cb+1]}, 64'hF3);
      check("t4_addr1", {52'd0, cl_a[cb+1]}, 64'h002);
    end
    rd(15'h0010);
    idle(2);
    check("t4_read", {32'd0, last_rd}, 64'hBBBB_AAAA);

    // Reset while the write is in its data phase: it must be dropped
    base = cen_cnt;
    bus(1'b1, T_NSEQ, 1'b1, 15'h0020, 3'd2, 32'h1234_5678, 1'b1, 1'b0);
    HSEL = 1'b0; HTRANS = T_IDLE; HWDATA = nxt_wd; nxt_wd = 32'd0;
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    idle(4);
    check("t5_no_access", 64'(cen_cnt - base), 64'd0);
    rd(15'h0020);
    idle(2);
    check("t5_old_data", {32'd0, last_rd}, {32'd0, ref_word(15'h0020)});

    // Unselected / non-active transfers leave the macro idle
    base = cen_cnt;
    bus(1'b0, T_NSEQ, 1'b1, 15'h0030, 3'd2, 32'h1, 1'b1, 1'b1);
    bus(1'b0, T_NSEQ, 1'b0, 15'h0030, 3'd2, 32'h0, 1'b1, 1'b1);
    bus(1'b1, T_IDLE, 1'b1, 15'h0030, 3'd2, 32'h2, 1'b1, 1'b1);
    bus(1'b1, T_BUSY, 1'b0, 15'h0030, 3'd2, 32'h0, 1'b1, 1'b1);
    bus(1'b1, T_NSEQ, 1'b0, 15'h0030, 3'd2, 32'h0, 1'b0, 1'b1);
    idle(1);
    check("t6_no_access", 64'(cen_cnt - base), 64'd0);

    // Random traffic over a small window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 3));
      a  = AW'($urandom_range(0, 255));
      a  = a & ~AW'(xfer_bytes(sz) - 1);
      if (r < 2)      bus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 1)), 1'($urandom), a, sz, $urandom, 1'b1, 1'b1);
      else if (r < 6) bus(1'b1, ($urandom_range(0, 1) == 1) ? T_SEQ : T_NSEQ, 1'b1, a, sz, $urandom, 1'b1, 1'b1);
      else            bus(1'b1, T_NSEQ, 1'b0, a, sz, 32'd0, 1'b1, 1'b1);
    end
    idle(4);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    for (int w = 0; w < 40; w++)
      check($sformatf("mem_w%0d", w), smem[w],
            {ref_mem[8*w+7], ref_mem[8*w+6], ref_mem[8*w+5], ref_mem[8*w+4],
             ref_mem[8*w+3], ref_mem[8*w+2], ref_mem[8*w+1], ref_mem[8*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram64_bridge.md
AHB_SRAM64_BRIDGE -- requirements
Module: ahb_sram64_bridge

Interface
REQ-001 Parameter AW, default 15, byte-address width; SRAM word address is AW-3 bits (12 for 4K x 64).
REQ-002 CLK  in  1  sole clock; all state on rising edge.
REQ-003 RESETn  in  1  asynchronous active-low reset.
REQ-004 HSEL  in  1  AHB-Lite slave select.
REQ-005 HADDR  in  AW  byte address.
REQ-006 HTRANS  in  2  transfer type; NONSEQ/SEQ are active.
REQ-007 HSIZE  in  3  0=byte, 1=halfword, 2=word; values >2 handled as word.
REQ-008 HWRITE  in  1  1=write.
REQ-009 HWDATA  in  32  write data, valid in data phase.
REQ-010 HREADY  in  1  bus-level ready.
REQ-011 HREADYOUT  out  1  slave ready; constant 1.
REQ-012 HRDATA  out  32  read data.
REQ-013 HRESP  out  1  constant 0 (OKAY).
REQ-014 SRAM_CEn  out  1  macro chip enable, active low.
REQ-015 SRAM_WEn  out  8  per-byte write enable, active low; all-ones means read.
REQ-016 SRAM_A  out  AW-3  word address.
REQ-017 SRAM_D  out  64  write data.
REQ-018 SRAM_Q  in  64  read data, valid the cycle after a CEn-low read.

Function
REQ-019 Accepted transfer = HSEL & HTRANS[1] & HREADY; zero wait states, no ERROR responses.
REQ-020 Byte-lane mask: byte -> lane HADDR[2:0]; halfword -> lanes {HADDR[2:1],0..1}; word -> lanes {HADDR[2],00..11}.
REQ-021 Accepted read: same cycle SRAM_CEn=0, SRAM_WEn=8'hFF, SRAM_A=HADDR[AW-1:3]; register HADDR[AW-1:2] for the data phase.
REQ-022 Read data phase: HRDATA = SRAM_Q[63:32] if registered HADDR[2]=1, else SRAM_Q[31:0].
REQ-023 Write buffer has three states: EMPTY, ADDR (address and mask captured, awaiting HWDATA), FULL (address, mask and data held).
REQ-024 Accepted write: capture word address and mask; go to ADDR. If FULL in that cycle, commit the old entry in the same cycle.
REQ-025 ADDR state: on the next rising edge, register HWDATA into the buffer; go to FULL, or to ADDR if a new write is accepted that cycle.
REQ-026 Commit: in any cycle with buffer FULL and no accepted read, drive SRAM_CEn=0, SRAM_A=buffer address, SRAM_WEn=~mask and SRAM_D={data,data}; go to EMPTY unless a new write is accepted.
REQ-027 Accepted read has priority over commit; a FULL buffer waits indefinitely across back-to-back reads.
REQ-028 Read-after-write forwarding: in a read data phase, for each byte lane with buffer FULL, address equal to the read word address and mask bit set, replace that HRDATA byte with buffer data.
REQ-029 Forwarding applies to a read whose address phase overlaps the write's data phase.
REQ-030 No SRAM access otherwise: SRAM_CEn=1, SRAM_WEn=8'hFF.
REQ-031 IDLE/BUSY transfers and HSEL=0 cause no state change.

Reset
REQ-032 On RESETn low: buffer EMPTY, SRAM_CEn=1, SRAM_WEn=8'hFF, HREADYOUT=1, HRESP=0, registered read address 0.
REQ-033 A pending (ADDR or FULL) write is discarded on reset and never reaches the SRAM.

Structure
REQ-034 Package ahb_sram64_pkg holds the HTRANS/HSIZE encodings, the buffer-state enum and the lane-mask function.
REQ-035 One sub-module, ahb_sram64_wbuf, holds the write buffer, the commit logic and the forwarding-compare logic.

Verification
REQ-036 Word write 0xDEADBEEF @0x0104, then idle -> one commit cycle with A=0x020, WEn=8'h0F, D[63:32]=0xDEADBEEF.
REQ-037 Byte write 0x55 @0x0003, then immediate word read @0x0000 (memory 0x11223344) -> HRDATA=0x55223344 with zero wait states.
REQ-038 Write @0x0008 followed by 5 back-to-back reads -> no commit during the reads; commit in the first idle cycle; later read @0x0008 returns the written value.
REQ-039 Two back-to-back halfword writes (0xAAAA @0x0010, 0xBBBB @0x0012) -> two commits, with WEn=8'hFC then 8'hF3; read @0x0010 returns 0xBBBBAAAA.
REQ-040 Write to 0x0020, then RESETn asserted before the commit -> SRAM_CEn stays 1; read @0x0020 returns the old contents.
REQ-041 HSEL=0 with HTRANS=NONSEQ, and HTRANS=IDLE with HSEL=1 -> SRAM_CEn stays 1 and HREADYOUT=1 throughout.
